// File: rtl/sprite_line_compositor.sv
// Per-scanline sprite compositor: scans all sprite slots during horizontal blank into a
// short per-line list, then hit-tests each active pixel against that list in two pipeline stages.
module sprite_line_compositor #(
    parameter int N_SPRITES    = 50,
    parameter int MAX_PER_LINE = 8,
    parameter int COORD_W      = 10,
    parameter int SIZE_W       = 5,
    parameter int PAL_W        = 3,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int PLAY_X_MIN   = 140,
    parameter int PLAY_X_MAX   = 500,
    parameter int BORDER_PAL   = 6
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [COORD_W-1:0]             draw_x_i,
    input  logic [COORD_W-1:0]             draw_y_i,
    input  logic [PAL_W-1:0]               back_pal_i,
    input  logic [N_SPRITES*COORD_W-1:0]   spr_x_i,
    input  logic [N_SPRITES*COORD_W-1:0]   spr_y_i,
    input  logic [N_SPRITES*SIZE_W-1:0]    spr_size_i,
    input  logic [N_SPRITES*PAL_W-1:0]     spr_pal_i,
    input  logic [N_SPRITES-1:0]           spr_on_i,
    output logic [PAL_W-1:0]               pal_ind_o,
    output logic                           hit_valid_o,
    output logic [((N_SPRITES > 1) ? $clog2(N_SPRITES) : 1)-1:0] hit_id_o,
    output logic [SIZE_W:0]                rel_x_o,
    output logic [SIZE_W:0]                rel_y_o,
    output logic                           line_overflow_o,
    output logic                           busy_o
);
    localparam int ID_W  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int EI_W  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam int SW    = COORD_W + 2;
    localparam int REL_W = SIZE_W + 1;

    localparam logic [COORD_W-1:0] H_ACT_C   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] LAST_LINE = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] PMIN_C    = COORD_W'(PLAY_X_MIN);
    localparam logic [COORD_W-1:0] PMAX_C    = COORD_W'(PLAY_X_MAX);
    localparam logic [PAL_W-1:0]   BORDER_C  = PAL_W'(BORDER_PAL);
    localparam logic [CNT_W-1:0]   MAX_C     = CNT_W'(MAX_PER_LINE);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_SPRITES - 1);
    // A scan that cannot finish inside the blank would commit mid-line, so it is never started.
    localparam bit SCAN_FITS = (N_SPRITES + 4 <= H_TOTAL - H_ACTIVE);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    idx_q, idx_d;
    logic [COORD_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]   sh_cnt_q, sh_cnt_d, act_cnt_q;
    logic               sh_ovf_q, sh_ovf_d, act_ovf_q;
    logic               append, commit;

    logic [ID_W-1:0]    sh_id_q  [MAX_PER_LINE];
    logic [COORD_W-1:0] sh_x_q   [MAX_PER_LINE];
    logic [COORD_W-1:0] sh_y_q   [MAX_PER_LINE];
    logic [SIZE_W-1:0]  sh_sz_q  [MAX_PER_LINE];
    logic [PAL_W-1:0]   sh_pal_q [MAX_PER_LINE];
    logic [ID_W-1:0]    act_id_q [MAX_PER_LINE];
    logic [COORD_W-1:0] act_x_q  [MAX_PER_LINE];
    logic [COORD_W-1:0] act_y_q  [MAX_PER_LINE];
    logic [SIZE_W-1:0]  act_sz_q [MAX_PER_LINE];
    logic [PAL_W-1:0]   act_pal_q[MAX_PER_LINE];

    logic [COORD_W-1:0] spr_x_a  [N_SPRITES];
    logic [COORD_W-1:0] spr_y_a  [N_SPRITES];
    logic [SIZE_W-1:0]  spr_sz_a [N_SPRITES];
    logic [PAL_W-1:0]   spr_pal_a[N_SPRITES];

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_unpack
        assign spr_x_a[gi]   = spr_x_i[gi*COORD_W +: COORD_W];
        assign spr_y_a[gi]   = spr_y_i[gi*COORD_W +: COORD_W];
        assign spr_sz_a[gi]  = spr_size_i[gi*SIZE_W +: SIZE_W];
        assign spr_pal_a[gi] = spr_pal_i[gi*PAL_W +: PAL_W];
    end

    logic [COORD_W-1:0] cur_x, cur_y;
    logic [SIZE_W-1:0]  cur_sz;
    logic [PAL_W-1:0]   cur_pal;
    logic signed [SW-1:0] tgt_s, y_lo, y_hi;
    logic               slot_hit;

    assign cur_x    = spr_x_a[idx_q];
    assign cur_y    = spr_y_a[idx_q];
    assign cur_sz   = spr_sz_a[idx_q];
    assign cur_pal  = spr_pal_a[idx_q];
    assign tgt_s    = $signed({2'b00, target_q});
    assign y_lo     = $signed({2'b00, cur_y}) - $signed({{(SW-SIZE_W){1'b0}}, cur_sz});
    assign y_hi     = $signed({2'b00, cur_y}) + $signed({{(SW-SIZE_W){1'b0}}, cur_sz});
    assign slot_hit = spr_on_i[idx_q] && (tgt_s >= y_lo) && (tgt_s <= y_hi);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        sh_cnt_d = sh_cnt_q;
        sh_ovf_d = sh_ovf_q;
        append   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (SCAN_FITS && draw_x_i == H_ACT_C) begin
                    state_d  = SCAN;
                    target_d = (draw_y_i == LAST_LINE) ? '0 : draw_y_i + COORD_W'(1);
                    sh_cnt_d = '0;
                    sh_ovf_d = 1'b0;
                    idx_d    = '0;
                end
            end
            SCAN: begin
                if (slot_hit) begin
                    if (sh_cnt_q < MAX_C) begin
                        append   = 1'b1;
                        sh_cnt_d = sh_cnt_q + CNT_W'(1);
                    end else begin
                        sh_ovf_d = 1'b1;
                    end
                end
                if (idx_q == LAST_ID) state_d = COMMIT;
                else                  idx_d   = idx_q + ID_W'(1);
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            target_q  <= '0;
            sh_cnt_q  <= '0;
            sh_ovf_q  <= 1'b0;
            act_cnt_q <= '0;
            act_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            sh_cnt_q <= sh_cnt_d;
            sh_ovf_q <= sh_ovf_d;
            if (commit) begin
                act_cnt_q <= sh_cnt_q;
                act_ovf_q <= sh_ovf_q;
            end
        end
    end

    // Each list entry owns its storage; the shadow slot at the current count takes the append.
    logic [MAX_PER_LINE-1:0] hit_vec;
    logic signed [SW-1:0]    dx_s;
    assign dx_s = $signed({2'b00, draw_x_i});

    for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sh_id_q[gi]   <= '0;
                sh_x_q[gi]    <= '0;
                sh_y_q[gi]    <= '0;
                sh_sz_q[gi]   <= '0;
                sh_pal_q[gi]  <= '0;
                act_id_q[gi]  <= '0;
                act_x_q[gi]   <= '0;
                act_y_q[gi]   <= '0;
                act_sz_q[gi]  <= '0;
                act_pal_q[gi] <= '0;
            end else begin
                if (append && sh_cnt_q == CNT_W'(gi)) begin
                    sh_id_q[gi]  <= idx_q;
                    sh_x_q[gi]   <= cur_x;
                    sh_y_q[gi]   <= cur_y;
                    sh_sz_q[gi]  <= cur_sz;
                    sh_pal_q[gi] <= cur_pal;
                end
                if (commit) begin
                    act_id_q[gi]  <= sh_id_q[gi];
                    act_x_q[gi]   <= sh_x_q[gi];
                    act_y_q[gi]   <= sh_y_q[gi];
                    act_sz_q[gi]  <= sh_sz_q[gi];
                    act_pal_q[gi] <= sh_pal_q[gi];
                end
            end
        end

        logic signed [SW-1:0] x_lo, x_hi;
        assign x_lo = $signed({2'b00, act_x_q[gi]}) - $signed({{(SW-SIZE_W){1'b0}}, act_sz_q[gi]});
        assign x_hi = $signed({2'b00, act_x_q[gi]}) + $signed({{(SW-SIZE_W){1'b0}}, act_sz_q[gi]});
        assign hit_vec[gi] = (CNT_W'(gi) < act_cnt_q) && (dx_s >= x_lo) && (dx_s <= x_hi);
    end

    logic [MAX_PER_LINE-1:0] s1_hit_q;
    logic [COORD_W-1:0]      s1_x_q, s1_y_q;
    logic [PAL_W-1:0]        s1_pal_q;
    logic                    s1_act_q;

    logic                    sel_valid;
    logic [EI_W-1:0]         sel;
    logic [PAL_W-1:0]        pal_d, pal_q;
    logic                    hv_d, hv_q;
    logic [ID_W-1:0]         id_d, id_q;
    logic [REL_W-1:0]        relx_d, relx_q, rely_d, rely_q;

    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        for (int e = MAX_PER_LINE - 1; e >= 0; e--) begin
            if (s1_hit_q[e]) begin
                sel_valid = 1'b1;
                sel       = EI_W'(e);
            end
        end
        pal_d  = '0;
        hv_d   = 1'b0;
        id_d   = '0;
        relx_d = '0;
        rely_d = '0;
        if (s1_act_q) begin
            if (sel_valid) begin
                pal_d  = act_pal_q[sel];
                hv_d   = 1'b1;
                id_d   = act_id_q[sel];
                relx_d = REL_W'(s1_x_q) - (REL_W'(act_x_q[sel]) - REL_W'(act_sz_q[sel]));
                rely_d = REL_W'(s1_y_q) - (REL_W'(act_y_q[sel]) - REL_W'(act_sz_q[sel]));
            end else if (s1_x_q >= PMIN_C && s1_x_q <= PMAX_C) begin
                pal_d = s1_pal_q;
            end else begin
                pal_d = BORDER_C;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_hit_q <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_pal_q <= '0;
            s1_act_q <= 1'b0;
            pal_q    <= '0;
            hv_q     <= 1'b0;
            id_q     <= '0;
            relx_q   <= '0;
            rely_q   <= '0;
        end else begin
            s1_hit_q <= hit_vec;
            s1_x_q   <= draw_x_i;
            s1_y_q   <= draw_y_i;
            s1_pal_q <= back_pal_i;
            s1_act_q <= (draw_x_i < H_ACT_C) && (draw_y_i < V_ACT_C);
            pal_q    <= pal_d;
            hv_q     <= hv_d;
            id_q     <= id_d;
            relx_q   <= relx_d;
            rely_q   <= rely_d;
        end
    end

    assign pal_ind_o       = pal_q;
    assign hit_valid_o     = hv_q;
    assign hit_id_o        = id_q;
    assign rel_x_o         = relx_q;
    assign rel_y_o         = rely_q;
    assign line_overflow_o = act_ovf_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_compositor.sv
// Directed bench for sprite_line_compositor: each task drives one scenario and checks outputs
// against hand-computed values.
module tb_sprite_line_compositor;
    localparam int N  = 50;
    localparam int CW = 10;
    localparam int SW = 5;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CW-1:0]   draw_x, draw_y;
    logic [PW-1:0]   back_pal;
    logic [N*CW-1:0] spr_x, spr_y;
    logic [N*SW-1:0] spr_size;
    logic [N*PW-1:0] spr_pal;
    logic [N-1:0]    spr_on;
    logic [PW-1:0]   pal_ind;
    logic            hit_valid;
    logic [5:0]      hit_id;
    logic [SW:0]     rel_x, rel_y;
    logic            line_ovf;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sprite_line_compositor dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .draw_x_i(draw_x), .draw_y_i(draw_y), .back_pal_i(back_pal),
        .spr_x_i(spr_x), .spr_y_i(spr_y), .spr_size_i(spr_size),
        .spr_pal_i(spr_pal), .spr_on_i(spr_on),
        .pal_ind_o(pal_ind), .hit_valid_o(hit_valid), .hit_id_o(hit_id),
        .rel_x_o(rel_x), .rel_y_o(rel_y),
        .line_overflow_o(line_ovf), .busy_o(busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spr(input int s, input int x, input int y, input int sz, input int pal, input bit on);
        spr_x[s*CW +: CW]    = CW'(x);
        spr_y[s*CW +: CW]    = CW'(y);
        spr_size[s*SW +: SW] = SW'(sz);
        spr_pal[s*PW +: PW]  = PW'(pal);
        spr_on[s]            = on;
    endtask

    task automatic clear_spr();
        spr_x = '0; spr_y = '0; spr_size = '0; spr_pal = '0; spr_on = '0;
    endtask

    // Hblank scan for line y: trigger at DrawX 640, then run past scan and commit.
    task automatic do_scan(input int y);
        draw_y = CW'(y);
        draw_x = 10'd640;
        tick();
        for (int k = 1; k < 54; k++) begin
            draw_x = CW'(640 + k);
            tick();
        end
        $display("scan y=%0d ovf=%0d busy=%0d", y, line_ovf, busy);
    endtask

    // Hold one pixel for two clocks so the registered output belongs to it.
    task automatic pix(input int x);
        draw_x = CW'(x);
        tick();
        tick();
        $display("pix y=%0d x=%0d pal=%0d hit=%0d id=%0d relx=%0d rely=%0d ovf=%0d",
                 draw_y, x, pal_ind, hit_valid, hit_id, rel_x, rel_y, line_ovf);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        draw_x = '0; draw_y = '0; back_pal = 3'd5;
        clear_spr();
        tick(); tick();
        total++; if (pal_ind !== 3'd0)   begin bad++; $display("FAIL reset_pal got=%0d exp=0", pal_ind); end
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL reset_hv got=%0d exp=0", hit_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        total++; if (line_ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0d exp=0", line_ovf); end
        total++; if (rel_x !== 6'd0 || rel_y !== 6'd0 || hit_id !== 6'd0)
            begin bad++; $display("FAIL reset_meta got=%0d/%0d/%0d exp=0/0/0", rel_x, rel_y, hit_id); end
        rst_n = 1'b1;
        set_spr(3, 200, 100, 8, 4, 1'b1);
        draw_y = 10'd100;
        pix(200);
        total++; if (hit_valid !== 1'b0 || pal_ind !== 3'd5)
            begin bad++; $display("FAIL reset_firstline got=%0d/%0d exp=0/5", hit_valid, pal_ind); end
    endtask

    task automatic test_background();
        int xs[9]  = '{139, 140, 501, 500, 641, 320, 700, 10, 639};
        int exp[9] = '{6,   5,   6,   5,   0,   5,   0,   6,  6};
        draw_y = 10'd10;
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) draw_x = CW'(xs[i]);
            tick();
            if (i >= 1) begin
                $display("bg x=%0d pal=%0d hit=%0d", xs[i-1], pal_ind, hit_valid);
                total++; if (pal_ind !== PW'(exp[i-1]) || hit_valid !== 1'b0)
                    begin bad++; $display("FAIL bg_x%0d got=%0d exp=%0d", xs[i-1], pal_ind, exp[i-1]); end
            end
        end
        draw_y = 10'd480;
        pix(300);
        total++; if (pal_ind !== 3'd0) begin bad++; $display("FAIL bg_vblank got=%0d exp=0", pal_ind); end
    endtask

    task automatic test_busy();
        draw_y = 10'd20;
        draw_x = 10'd640;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_pre got=%0d exp=0", busy); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_start got=%0d exp=1", busy); end
        for (int k = 1; k <= 50; k++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_commit got=%0d exp=1", busy); end
        draw_x = 10'd700;
        tick();
        $display("busy after commit=%0d", busy);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_end got=%0d exp=0", busy); end
    endtask

    task automatic test_one_sprite();
        do_scan(99);
        draw_y = 10'd100;
        pix(191);
        total++; if (pal_ind !== 3'd5 || hit_valid !== 1'b0)
            begin bad++; $display("FAIL one_191 got=%0d/%0d exp=5/0", pal_ind, hit_valid); end
        pix(192);
        total++; if (pal_ind !== 3'd4 || hit_valid !== 1'b1 || hit_id !== 6'd3)
            begin bad++; $display("FAIL one_192 got=%0d/%0d/%0d exp=4/1/3", pal_ind, hit_valid, hit_id); end
        total++; if (rel_x !== 6'd0 || rel_y !== 6'd8)
            begin bad++; $display("FAIL one_rel192 got=%0d/%0d exp=0/8", rel_x, rel_y); end
        pix(200);
        total++; if (pal_ind !== 3'd4 || rel_x !== 6'd8)
            begin bad++; $display("FAIL one_200 got=%0d/%0d exp=4/8", pal_ind, rel_x); end
        pix(208);
        total++; if (pal_ind !== 3'd4 || rel_x !== 6'd16 || hit_id !== 6'd3)
            begin bad++; $display("FAIL one_208 got=%0d/%0d/%0d exp=4/16/3", pal_ind, rel_x, hit_id); end
        pix(209);
        total++; if (pal_ind !== 3'd5 || hit_valid !== 1'b0)
            begin bad++; $display("FAIL one_209 got=%0d/%0d exp=5/0", pal_ind, hit_valid); end
        total++; if (line_ovf !== 1'b0) begin bad++; $display("FAIL one_ovf got=%0d exp=0", line_ovf); end
    endtask

    task automatic test_priority();
        clear_spr();
        set_spr(1,  300, 200, 4, 2, 1'b1);
        set_spr(20, 300, 200, 6, 3, 1'b1);
        do_scan(199);
        draw_y = 10'd200;
        pix(300);
        total++; if (pal_ind !== 3'd2 || hit_id !== 6'd1)
            begin bad++; $display("FAIL prio_both got=%0d/%0d exp=2/1", pal_ind, hit_id); end
        pix(305);
        total++; if (pal_ind !== 3'd3 || hit_id !== 6'd20 || rel_x !== 6'd11)
            begin bad++; $display("FAIL prio_edge got=%0d/%0d/%0d exp=3/20/11", pal_ind, hit_id, rel_x); end
        spr_on[1] = 1'b0;
        do_scan(199);
        draw_y = 10'd200;
        pix(300);
        total++; if (pal_ind !== 3'd3 || hit_id !== 6'd20)
            begin bad++; $display("FAIL prio_off got=%0d/%0d exp=3/20", pal_ind, hit_id); end
        total++; if (rel_x !== 6'd6 || rel_y !== 6'd6)
            begin bad++; $display("FAIL prio_rel got=%0d/%0d exp=6/6", rel_x, rel_y); end
    endtask

    task automatic test_overflow();
        clear_spr();
        for (int i = 0; i < 10; i++) set_spr(i, 150 + 30*i, 150, 0, 7, 1'b1);
        do_scan(148);
        draw_y = 10'd149;
        total++; if (line_ovf !== 1'b0) begin bad++; $display("FAIL ovf_149 got=%0d exp=0", line_ovf); end
        pix(150);
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL ovf_149hit got=%0d exp=0", hit_valid); end
        do_scan(149);
        draw_y = 10'd150;
        total++; if (line_ovf !== 1'b1) begin bad++; $display("FAIL ovf_150 got=%0d exp=1", line_ovf); end
        pix(150);
        total++; if (hit_valid !== 1'b1 || hit_id !== 6'd0 || pal_ind !== 3'd7)
            begin bad++; $display("FAIL ovf_slot0 got=%0d/%0d/%0d exp=1/0/7", hit_valid, hit_id, pal_ind); end
        pix(360);
        total++; if (hit_valid !== 1'b1 || hit_id !== 6'd7)
            begin bad++; $display("FAIL ovf_slot7 got=%0d/%0d exp=1/7", hit_valid, hit_id); end
        pix(390);
        total++; if (hit_valid !== 1'b0 || pal_ind !== 3'd5)
            begin bad++; $display("FAIL ovf_slot8 got=%0d/%0d exp=0/5", hit_valid, pal_ind); end
        pix(420);
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL ovf_slot9 got=%0d exp=0", hit_valid); end
        total++; if (line_ovf !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%0d exp=1", line_ovf); end
        do_scan(150);
        total++; if (line_ovf !== 1'b0) begin bad++; $display("FAIL ovf_151 got=%0d exp=0", line_ovf); end
    endtask

    task automatic test_reset_midscan();
        do_scan(149);
        clear_spr();
        set_spr(3, 200, 100, 8, 4, 1'b1);
        draw_y = 10'd99;
        draw_x = 10'd640;
        tick();
        for (int k = 1; k <= 25; k++) begin
            draw_x = CW'(640 + k);
            tick();
        end
        total++; if (busy !== 1'b1 || line_ovf !== 1'b1)
            begin bad++; $display("FAIL mid_pre got=%0d/%0d exp=1/1", busy, line_ovf); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || line_ovf !== 1'b0)
            begin bad++; $display("FAIL mid_rst got=%0d/%0d exp=0/0", busy, line_ovf); end
        total++; if (pal_ind !== 3'd0 || hit_valid !== 1'b0)
            begin bad++; $display("FAIL mid_rst_out got=%0d/%0d exp=0/0", pal_ind, hit_valid); end
        tick();
        rst_n = 1'b1;
        draw_y = 10'd100;
        pix(200);
        total++; if (hit_valid !== 1'b0 || pal_ind !== 3'd5)
            begin bad++; $display("FAIL mid_next got=%0d/%0d exp=0/5", hit_valid, pal_ind); end
        do_scan(100);
        draw_y = 10'd101;
        pix(200);
        total++; if (pal_ind !== 3'd4 || hit_id !== 6'd3 || rel_x !== 6'd8 || rel_y !== 6'd9)
            begin bad++; $display("FAIL mid_after got=%0d/%0d/%0d/%0d exp=4/3/8/9", pal_ind, hit_id, rel_x, rel_y); end
    endtask

    task automatic test_boundaries();
        clear_spr();
        set_spr(5, 250,  3,  9, 1, 1'b1);
        set_spr(6, 1020, 0, 10, 2, 1'b1);
        do_scan(524);
        draw_y = 10'd0;
        pix(250);
        total++; if (pal_ind !== 3'd1 || hit_id !== 6'd5 || rel_y !== 6'd6 || rel_x !== 6'd9)
            begin bad++; $display("FAIL bnd_top got=%0d/%0d/%0d/%0d exp=1/5/6/9", pal_ind, hit_id, rel_y, rel_x); end
        pix(241);
        total++; if (pal_ind !== 3'd1 || rel_x !== 6'd0)
            begin bad++; $display("FAIL bnd_left got=%0d/%0d exp=1/0", pal_ind, rel_x); end
        pix(0);
        total++; if (hit_valid !== 1'b0 || pal_ind !== 3'd6)
            begin bad++; $display("FAIL bnd_x0 got=%0d/%0d exp=0/6", hit_valid, pal_ind); end
        pix(5);
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL bnd_x5 got=%0d exp=0", hit_valid); end
        total++; if (line_ovf !== 1'b0) begin bad++; $display("FAIL bnd_ovf got=%0d exp=0", line_ovf); end
    endtask

    initial begin
        test_reset();
        test_background();
        test_busy();
        test_one_sprite();
        test_priority();
        test_overflow();
        test_reset_midscan();
        test_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_compositor.md
# sprite_line_compositor

Parametrised, pipelined successor to the combinational per-pixel colour mapper. During each horizontal blank it scans every sprite, one per clock, and builds a per-line list of up to MAX_PER_LINE sprites that intersect the next scanline. During active video it hit-tests DrawX against that list in parallel and emits a registered palette index plus hit metadata for downstream shape ROMs. It sits between the game-state logic (sprite positions) and the palette lookup in the HDMI path.

## Interface
- N_SPRITES, 50, number of sprite slots; must be ≤ H_TOTAL−H_ACTIVE−4
- MAX_PER_LINE, 8, sprite list entries per scanline
- COORD_W, 10, coordinate width
- SIZE_W, 5, half-extent width (box is 2·size+1 square)
- PAL_W, 3, palette index width
- H_ACTIVE / H_TOTAL / V_ACTIVE / V_TOTAL, 640 / 800 / 480 / 525, timing
- PLAY_X_MIN / PLAY_X_MAX, 140 / 500, background column range (inclusive)
- BORDER_PAL, 6, palette index outside the play field
- Clk  in  1  pixel clock; DrawX advances once per cycle
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- DrawX, DrawY  in  COORD_W each  current raster position
- BackPal  in  PAL_W  background index, valid with the same-cycle DrawX
- SprX, SprY  in  N_SPRITES·COORD_W each  flattened centres, slot i at [i·COORD_W +: COORD_W]
- SprSize  in  N_SPRITES·SIZE_W  half-extents
- SprPal  in  N_SPRITES·PAL_W  palette index per slot
- SprOn  in  N_SPRITES  slot enables
- PalInd  out  PAL_W  composited palette index
- HitValid  out  1  a sprite covers the pixel
- HitId  out  $clog2(N_SPRITES)  winning slot
- RelX, RelY  out  SIZE_W+1 each  pixel offset from the sprite's top-left corner
- LineOverflow  out  1  the displayed line dropped at least one sprite
- Busy  out  1  scan in progress

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- IDLE→SCAN when DrawX == H_ACTIVE. On entry, capture target = DrawY+1, or 0 when DrawY == V_TOTAL−1. Clear the shadow count and shadow overflow. Set idx = 0.
- SCAN: each cycle, test slot idx. The slot is a hit when SprOn[idx] is set and target−SprY ∈ [−size, +size].
- All box arithmetic uses signed COORD_W+2 bits, so Y−size < 0 and X+size > 1023 never wrap.
- On a hit with count < MAX_PER_LINE, append {idx, X, Y, size, pal} to the shadow list and increment count.
- On a hit with count == MAX_PER_LINE, set the shadow overflow bit and discard the slot.
- After idx == N_SPRITES−1, go to COMMIT.
- COMMIT (1 cycle): copy the shadow list, count and overflow into the active set, then return to IDLE.
- List entries are in ascending slot order, so the lowest slot wins, e.g. player/shot in low slots above invaders.
- Pixel stage 1: compare DrawX against every active entry below count in parallel, using X−size ≤ DrawX ≤ X+size.
- Stage 1 registers the hit vector, DrawX, BackPal, and whether the pixel is active (DrawX < H_ACTIVE and DrawY < V_ACTIVE).
- Pixel stage 2: a priority encoder selects the lowest-index hit. Outputs are registered.
  - not active → PalInd = 0, HitValid = 0
  - hit → PalInd = entry pal, HitId = entry slot, RelX = DrawX−(X−size), RelY = current line−(Y−size)
  - no hit, DrawX within [PLAY_X_MIN, PLAY_X_MAX] → BackPal
  - otherwise → BORDER_PAL
- Sprite inputs are sampled only during SCAN. Changes mid-line take effect on the next line, so there is no intra-line tearing.
- Size 0 is a 1×1 box. Disabled slots never appear.

## Timing
- Reset (asynchronous, Reset_n = 0): FSM to IDLE, active and shadow counts 0, all outputs 0, pipeline cleared.
- The first line after reset shows no sprites until one scan completes.
- Pixel latency is 2 cycles: outputs for DrawX at cycle t appear at t+2. The sync path must be delayed by 2 to match.
- Scan length is N_SPRITES cycles, plus 1 COMMIT cycle.
- Busy is high from the cycle after the trigger through COMMIT inclusive.
- The active list changes only in COMMIT, which always occurs inside horizontal blank.
- LineOverflow updates with COMMIT and holds for the whole following line.
- If DrawX == H_ACTIVE recurs while not IDLE, it is ignored. This cannot happen with legal parameters.
- Reset asserted mid-SCAN aborts the scan immediately. The partial shadow list is discarded.

## Test plan
- One sprite: slot 3 at (200,100), size 8, pal 4. Scan line 99. At DrawX 192–208 on line 100, PalInd = 4 and HitId = 3; at DrawX 192, RelX = 0 and RelY = 8. DrawX 191 and 209 give BackPal.
- Priority: slots 1 (pal 2) and 20 (pal 3) overlap at (300,200). The overlap shows pal 2 and HitId = 1. With slot 1 disabled, the overlap shows pal 3.
- Overflow: 10 sprites on line 150 with MAX_PER_LINE = 8. Slots 0–7 are visible, slots 8–9 never hit, and LineOverflow = 1 for line 150 only.
- Boundaries:
  - Sprite at Y = 3, size 9: visible on line 0 with no wrap.
  - Sprite at X = 1020, size 10: no false hit near DrawX 0.
  - DrawY = 524 scan targets line 0.
- Background/border, no sprites: DrawX 139 → 6, DrawX 140 → BackPal, DrawX 500 → BackPal, DrawX 501 → 6, DrawX ≥ 640 → 0. Each output appears exactly 2 cycles after its DrawX.
- Reset: pulse Reset_n low at scan idx 25. Outputs are 0 immediately. The next line shows no sprites, and the line after shows the correct list.
